// File: rtl/rs_sched.sv
// rs_sched: reservation station sitting directly behind the register alias
// table. Renamed instructions are captured with their operands (value or
// producer tag), waiting operands are woken by snooping the writeback bus,
// and one ready instruction per cycle is handed to a single functional unit
// through a registered valid/stall interface.
// Optional build macro: RS_AGE_SELECT_EN -- when defined, an age matrix picks
// the oldest ready entry; otherwise the lowest-index ready entry issues.

module rs_sched #(
    parameter int NENT = 8,
    parameter int OPW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rename_rs_valid,
    input  logic [OPW-1:0] rename_rs_op,
    input  logic [7:0]     rename_rs_robid,
    input  logic [5:0]     rename_rs_rd,
    input  logic           rat_rs1_valid,
    input  logic [31:0]    rat_rs1_tagval,
    input  logic           rat_rs2_valid,
    input  logic [31:0]    rat_rs2_tagval,
    output logic           rs_stall,
    input  logic           wb_valid,
    input  logic           wb_error,
    input  logic [7:0]     wb_robid,
    input  logic [31:0]    wb_result,
    input  logic           rob_flush,
    output logic           rs_fu_valid,
    input  logic           fu_rs_stall,
    output logic [OPW-1:0] rs_fu_op,
    output logic [7:0]     rs_fu_robid,
    output logic [5:0]     rs_fu_rd,
    output logic [31:0]    rs_fu_op1,
    output logic [31:0]    rs_fu_op2
);

    localparam int IDXW = (NENT > 1) ? $clog2(NENT) : 1;

    // Entry storage
    logic [NENT-1:0] busy_q, busy_d;
    logic [NENT-1:0] rdy1_q, rdy1_d;
    logic [NENT-1:0] rdy2_q, rdy2_d;
    logic [OPW-1:0]  op_q    [NENT];
    logic [OPW-1:0]  op_d    [NENT];
    logic [7:0]      robid_q [NENT];
    logic [7:0]      robid_d [NENT];
    logic [5:0]      rd_q    [NENT];
    logic [5:0]      rd_d    [NENT];
    logic [31:0]     val1_q  [NENT];
    logic [31:0]     val1_d  [NENT];
    logic [31:0]     val2_q  [NENT];
    logic [31:0]     val2_d  [NENT];

    // Issue register
    logic            fuValid_q;
    logic [OPW-1:0]  fuOp_q;
    logic [7:0]      fuRobid_q;
    logic [5:0]      fuRd_q;
    logic [31:0]     fuOp1_q;
    logic [31:0]     fuOp2_q;

    // Control
    logic            wbWake;
    logic            insEn;
    logic            freeFound;
    logic [IDXW-1:0] freeIdx;
    logic            ins1Match;
    logic            ins2Match;
    logic            ins1Rdy;
    logic            ins2Rdy;
    logic [31:0]     ins1Val;
    logic [31:0]     ins2Val;
    logic [NENT-1:0] wake1Vec;
    logic [NENT-1:0] wake2Vec;
    logic [NENT-1:0] readyVec;
    logic [NENT-1:0] grantVec;
    logic            selFound;
    logic [IDXW-1:0] selIdx;
    logic            issueOpen;
    logic            issueLoad;
    logic            unusedBits;

    // Only the low seven bits of a ROB id take part in tag matching.
    assign unusedBits = wb_robid[7];

    assign rs_stall  = &busy_q;
    assign wbWake    = wb_valid & ~wb_error;
    assign insEn     = rename_rs_valid & ~rs_stall;
    assign readyVec  = busy_q & rdy1_q & rdy2_q;
    assign issueOpen = ~fuValid_q | ~fu_rs_stall;
    assign issueLoad = issueOpen & selFound & ~rob_flush;

    // An operand arriving from the RAT as a tag can be satisfied by the very
    // broadcast happening in its insert cycle.
    assign ins1Match = wbWake & ~rat_rs1_valid & (rat_rs1_tagval[6:0] == wb_robid[6:0]);
    assign ins2Match = wbWake & ~rat_rs2_valid & (rat_rs2_tagval[6:0] == wb_robid[6:0]);
    assign ins1Rdy   = rat_rs1_valid | ins1Match;
    assign ins2Rdy   = rat_rs2_valid | ins2Match;
    assign ins1Val   = ins1Match ? wb_result : rat_rs1_tagval;
    assign ins2Val   = ins2Match ? wb_result : rat_rs2_tagval;

    // Lowest-index free slot receives the next insert.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = 0; i < NENT; i++) begin
            if (!busy_q[i] && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = IDXW'(i);
            end
        end
    end

    // Per-entry wakeup match against the current writeback broadcast.
    always_comb begin
        wake1Vec = '0;
        wake2Vec = '0;
        for (int i = 0; i < NENT; i++) begin
            wake1Vec[i] = wbWake & busy_q[i] & ~rdy1_q[i] & (val1_q[i][6:0] == wb_robid[6:0]);
            wake2Vec[i] = wbWake & busy_q[i] & ~rdy2_q[i] & (val2_q[i][6:0] == wb_robid[6:0]);
        end
    end

`ifdef RS_AGE_SELECT_EN
    // older_q[i][j] set means entry j was inserted before entry i.
    logic [NENT-1:0] older_q [NENT];
    logic [NENT-1:0] older_d [NENT];

    // A ready entry is granted only when no older entry is also ready.
    always_comb begin
        grantVec = '0;
        for (int i = 0; i < NENT; i++) begin
            grantVec[i] = readyVec[i] & ~|(older_q[i] & readyVec);
        end
    end

    // A new entry is younger than every busy entry and older than nobody.
    always_comb begin
        older_d = older_q;
        if (insEn) begin
            for (int i = 0; i < NENT; i++) begin
                older_d[i][freeIdx] = 1'b0;
            end
            older_d[freeIdx]          = busy_q;
            older_d[freeIdx][freeIdx] = 1'b0;
        end
    end

    // Age matrix storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            older_q <= older_d;
        end
    end
`else
    assign grantVec = readyVec;
`endif

    // Priority-encode the grant vector to the issuing slot.
    always_comb begin
        selFound = 1'b0;
        selIdx   = '0;
        for (int i = 0; i < NENT; i++) begin
            if (grantVec[i] && !selFound) begin
                selFound = 1'b1;
                selIdx   = IDXW'(i);
            end
        end
    end

    // Entry next state: wakeups, issue free, insert, then flush overriding all.
    always_comb begin
        busy_d  = busy_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        op_d    = op_q;
        robid_d = robid_q;
        rd_d    = rd_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        for (int i = 0; i < NENT; i++) begin
            if (wake1Vec[i]) begin
                rdy1_d[i] = 1'b1;
                val1_d[i] = wb_result;
            end
            if (wake2Vec[i]) begin
                rdy2_d[i] = 1'b1;
                val2_d[i] = wb_result;
            end
        end
        if (issueLoad) begin
            busy_d[selIdx] = 1'b0;
        end
        if (insEn) begin
            busy_d[freeIdx]  = 1'b1;
            rdy1_d[freeIdx]  = ins1Rdy;
            rdy2_d[freeIdx]  = ins2Rdy;
            op_d[freeIdx]    = rename_rs_op;
            robid_d[freeIdx] = rename_rs_robid;
            rd_d[freeIdx]    = rename_rs_rd;
            val1_d[freeIdx]  = ins1Val;
            val2_d[freeIdx]  = ins2Val;
        end
        if (rob_flush) begin
            busy_d = '0;
        end
    end

    // Entry storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            for (int i = 0; i < NENT; i++) begin
                op_q[i]    <= '0;
                robid_q[i] <= '0;
                rd_q[i]    <= '0;
                val1_q[i]  <= '0;
                val2_q[i]  <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            op_q    <= op_d;
            robid_q <= robid_d;
            rd_q    <= rd_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
        end
    end

    // Issue register: holds while stalled, otherwise loads the selected entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fuValid_q <= 1'b0;
            fuOp_q    <= '0;
            fuRobid_q <= '0;
            fuRd_q    <= '0;
            fuOp1_q   <= '0;
            fuOp2_q   <= '0;
        end else if (rob_flush) begin
            fuValid_q <= 1'b0;
        end else if (issueOpen) begin
            fuValid_q <= selFound;
            if (selFound) begin
                fuOp_q    <= op_q[selIdx];
                fuRobid_q <= robid_q[selIdx];
                fuRd_q    <= rd_q[selIdx];
                fuOp1_q   <= val1_q[selIdx];
                fuOp2_q   <= val2_q[selIdx];
            end
        end
    end

    assign rs_fu_valid = fuValid_q;
    assign rs_fu_op    = fuOp_q;
    assign rs_fu_robid = fuRobid_q;
    assign rs_fu_rd    = fuRd_q;
    assign rs_fu_op1   = fuOp1_q;
    assign rs_fu_op2   = fuOp2_q;

endmodule

// File: tb/tb_rs_sched.sv
// tb_rs_sched: directed-vector bench for the reservation station.
// Inputs change just after the falling edge; outputs are checked at the
// falling edge, i.e. half a cycle after the rising edge that produced them.

module tb_rs_sched;

    logic        clk;
    logic        rst;
    logic        rename_rs_valid;
    logic [7:0]  rename_rs_op;
    logic [7:0]  rename_rs_robid;
    logic [5:0]  rename_rs_rd;
    logic        rat_rs1_valid;
    logic [31:0] rat_rs1_tagval;
    logic        rat_rs2_valid;
    logic [31:0] rat_rs2_tagval;
    logic        rs_stall;
    logic        wb_valid;
    logic        wb_error;
    logic [7:0]  wb_robid;
    logic [31:0] wb_result;
    logic        rob_flush;
    logic        rs_fu_valid;
    logic        fu_rs_stall;
    logic [7:0]  rs_fu_op;
    logic [7:0]  rs_fu_robid;
    logic [5:0]  rs_fu_rd;
    logic [31:0] rs_fu_op1;
    logic [31:0] rs_fu_op2;

    int checkCount;
    int errorCount;

    rs_sched #(.NENT(8), .OPW(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .rename_rs_valid (rename_rs_valid),
        .rename_rs_op    (rename_rs_op),
        .rename_rs_robid (rename_rs_robid),
        .rename_rs_rd    (rename_rs_rd),
        .rat_rs1_valid   (rat_rs1_valid),
        .rat_rs1_tagval  (rat_rs1_tagval),
        .rat_rs2_valid   (rat_rs2_valid),
        .rat_rs2_tagval  (rat_rs2_tagval),
        .rs_stall        (rs_stall),
        .wb_valid        (wb_valid),
        .wb_error        (wb_error),
        .wb_robid        (wb_robid),
        .wb_result       (wb_result),
        .rob_flush       (rob_flush),
        .rs_fu_valid     (rs_fu_valid),
        .fu_rs_stall     (fu_rs_stall),
        .rs_fu_op        (rs_fu_op),
        .rs_fu_robid     (rs_fu_robid),
        .rs_fu_rd        (rs_fu_rd),
        .rs_fu_op1       (rs_fu_op1),
        .rs_fu_op2       (rs_fu_op2)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance through one rising edge and return at the next sampling point.
    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic driveInsert(input logic [7:0] robid, input logic v1, input logic [31:0] tv1,
                               input logic v2, input logic [31:0] tv2);
        rename_rs_valid = 1'b1;
        rename_rs_op    = robid ^ 8'hA5;
        rename_rs_robid = robid;
        rename_rs_rd    = robid[5:0];
        rat_rs1_valid   = v1;
        rat_rs1_tagval  = tv1;
        rat_rs2_valid   = v2;
        rat_rs2_tagval  = tv2;
    endtask

    task automatic clearInsert();
        rename_rs_valid = 1'b0;
        rename_rs_op    = '0;
        rename_rs_robid = '0;
        rename_rs_rd    = '0;
        rat_rs1_valid   = 1'b0;
        rat_rs1_tagval  = '0;
        rat_rs2_valid   = 1'b0;
        rat_rs2_tagval  = '0;
    endtask

    task automatic driveWb(input logic err, input logic [7:0] robid, input logic [31:0] result);
        wb_valid  = 1'b1;
        wb_error  = err;
        wb_robid  = robid;
        wb_result = result;
    endtask

    task automatic clearWb();
        wb_valid  = 1'b0;
        wb_error  = 1'b0;
        wb_robid  = '0;
        wb_result = '0;
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        rst         = 1'b1;
        rob_flush   = 1'b0;
        fu_rs_stall = 1'b0;
        clearInsert();
        clearWb();
        repeat (3) @(negedge clk);

        checkOutput("reset_valid", rs_fu_valid, 0);
        checkOutput("reset_stall", rs_stall, 0);
        checkOutput("reset_robid", rs_fu_robid, 0);
        rst = 1'b0;

        // Both operands ready: issue visible after the second edge.
        driveInsert(8'd5, 1'b1, 32'h11, 1'b1, 32'h22);
        applyStimulus();
        clearInsert();
        checkOutput("t1_not_yet", rs_fu_valid, 0);
        applyStimulus();
        checkOutput("t1_valid", rs_fu_valid, 1);
        checkOutput("t1_robid", rs_fu_robid, 8'd5);
        checkOutput("t1_op1", rs_fu_op1, 32'h11);
        checkOutput("t1_op2", rs_fu_op2, 32'h22);
        checkOutput("t1_op", rs_fu_op, 8'hA0);
        checkOutput("t1_rd", rs_fu_rd, 6'd5);
        checkOutput("t1_stall", rs_stall, 0);
        applyStimulus();
        checkOutput("t1_drain", rs_fu_valid, 0);

        // Wakeup by a broadcast the cycle after insert.
        driveInsert(8'd9, 1'b0, 32'h3, 1'b1, 32'h44);
        applyStimulus();
        clearInsert();
        driveWb(1'b0, 8'd3, 32'hDEADBEEF);
        checkOutput("t2_wait", rs_fu_valid, 0);
        applyStimulus();
        clearWb();
        checkOutput("t2_woken_not_sel", rs_fu_valid, 0);
        applyStimulus();
        checkOutput("t2_valid", rs_fu_valid, 1);
        checkOutput("t2_robid", rs_fu_robid, 8'd9);
        checkOutput("t2_op1", rs_fu_op1, 32'hDEADBEEF);
        checkOutput("t2_op2", rs_fu_op2, 32'h44);
        applyStimulus();
        checkOutput("t2_drain", rs_fu_valid, 0);

        // Broadcast coinciding with insert; robid bit 7 is ignored by the match.
        driveInsert(8'd11, 1'b0, 32'h5, 1'b1, 32'h66);
        driveWb(1'b0, 8'h85, 32'h55);
        applyStimulus();
        clearInsert();
        clearWb();
        checkOutput("t2b_not_yet", rs_fu_valid, 0);
        applyStimulus();
        checkOutput("t2b_valid", rs_fu_valid, 1);
        checkOutput("t2b_robid", rs_fu_robid, 8'd11);
        checkOutput("t2b_op1", rs_fu_op1, 32'h55);
        applyStimulus();

        // An error broadcast must not wake the waiting operand.
        driveInsert(8'd10, 1'b0, 32'h3, 1'b1, 32'h44);
        applyStimulus();
        clearInsert();
        driveWb(1'b1, 8'd3, 32'h0BAD);
        applyStimulus();
        clearWb();
        for (int k = 0; k < 4; k++) begin
            checkOutput("t2c_no_issue", rs_fu_valid, 0);
            applyStimulus();
        end
        rob_flush = 1'b1;
        applyStimulus();
        rob_flush = 1'b0;

        // Fill all entries on tag 7, overflow insert ignored, drain in order.
        for (int k = 0; k < 8; k++) begin
            driveInsert(8'(20 + k), 1'b0, 32'h7, 1'b0, 32'h7);
            applyStimulus();
        end
        clearInsert();
        checkOutput("t3_full", rs_stall, 1);
        driveInsert(8'd99, 1'b1, 32'h99, 1'b1, 32'h99);
        applyStimulus();
        clearInsert();
        checkOutput("t3_still_full", rs_stall, 1);
        checkOutput("t3_no_issue", rs_fu_valid, 0);
        driveWb(1'b0, 8'd7, 32'h77);
        applyStimulus();
        clearWb();
        checkOutput("t3_full_at_wake", rs_stall, 1);
        checkOutput("t3_not_sel", rs_fu_valid, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            checkOutput("t3_valid", rs_fu_valid, 1);
            checkOutput("t3_robid", rs_fu_robid, 32'(20 + k));
            checkOutput("t3_op1", rs_fu_op1, 32'h77);
            checkOutput("t3_op2", rs_fu_op2, 32'h77);
            if (k == 0) begin
                checkOutput("t3_stall_clear", rs_stall, 0);
            end
        end
        applyStimulus();
        checkOutput("t3_drain", rs_fu_valid, 0);
        checkOutput("t3_empty_stall", rs_stall, 0);

        // Output held stable under FU stall, then second issues once.
        driveInsert(8'd30, 1'b1, 32'h30, 1'b1, 32'h3A);
        applyStimulus();
        driveInsert(8'd31, 1'b1, 32'h31, 1'b1, 32'h3B);
        applyStimulus();
        clearInsert();
        fu_rs_stall = 1'b1;
        checkOutput("t4_first", rs_fu_robid, 8'd30);
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("t4_hold_valid", rs_fu_valid, 1);
            checkOutput("t4_hold_robid", rs_fu_robid, 8'd30);
            checkOutput("t4_hold_op1", rs_fu_op1, 32'h30);
            checkOutput("t4_hold_op2", rs_fu_op2, 32'h3A);
        end
        fu_rs_stall = 1'b0;
        applyStimulus();
        checkOutput("t4_second_valid", rs_fu_valid, 1);
        checkOutput("t4_second_robid", rs_fu_robid, 8'd31);
        checkOutput("t4_second_op1", rs_fu_op1, 32'h31);
        applyStimulus();
        checkOutput("t4_no_dup", rs_fu_valid, 0);

        // Flush drops a stalled output and all waiting entries.
        fu_rs_stall = 1'b1;
        driveInsert(8'd40, 1'b1, 32'h40, 1'b1, 32'h40);
        applyStimulus();
        for (int k = 1; k < 4; k++) begin
            driveInsert(8'(40 + k), 1'b0, 32'hC, 1'b1, 32'h0);
            applyStimulus();
        end
        clearInsert();
        checkOutput("t5_held", rs_fu_robid, 8'd40);
        checkOutput("t5_held_valid", rs_fu_valid, 1);
        rob_flush = 1'b1;
        applyStimulus();
        rob_flush   = 1'b0;
        fu_rs_stall = 1'b0;
        checkOutput("t5_flushed", rs_fu_valid, 0);
        checkOutput("t5_stall", rs_stall, 0);
        driveWb(1'b0, 8'hC, 32'hCC);
        applyStimulus();
        clearWb();
        checkOutput("t5_stale_wb", rs_fu_valid, 0);
        applyStimulus();
        checkOutput("t5_stale_wb2", rs_fu_valid, 0);

        // Older entry in slot 1 vs newer entry in slot 0, both ready together.
        fu_rs_stall = 1'b1;
        driveInsert(8'd60, 1'b1, 32'h60, 1'b1, 32'h60);
        applyStimulus();
        driveInsert(8'd61, 1'b0, 32'hE, 1'b1, 32'h61);
        applyStimulus();
        checkOutput("t6_first", rs_fu_robid, 8'd60);
        driveInsert(8'd62, 1'b1, 32'h62, 1'b1, 32'h62);
        applyStimulus();
        clearInsert();
        driveWb(1'b0, 8'hE, 32'hE0);
        applyStimulus();
        clearWb();
        checkOutput("t6_hold", rs_fu_robid, 8'd60);
        fu_rs_stall = 1'b0;
        applyStimulus();
`ifdef RS_AGE_SELECT_EN
        checkOutput("t6_sel_a", rs_fu_robid, 8'd61);
        checkOutput("t6_sel_a_op1", rs_fu_op1, 32'hE0);
        applyStimulus();
        checkOutput("t6_sel_b", rs_fu_robid, 8'd62);
`else
        checkOutput("t6_sel_a", rs_fu_robid, 8'd62);
        applyStimulus();
        checkOutput("t6_sel_b", rs_fu_robid, 8'd61);
        checkOutput("t6_sel_b_op1", rs_fu_op1, 32'hE0);
`endif
        checkOutput("t6_sel_b_valid", rs_fu_valid, 1);
        applyStimulus();
        checkOutput("t6_drain", rs_fu_valid, 0);

        // Asynchronous reset mid-operation leaves nothing behind.
        driveInsert(8'd70, 1'b1, 32'h70, 1'b1, 32'h70);
        applyStimulus();
        driveInsert(8'd71, 1'b1, 32'h71, 1'b1, 32'h71);
        applyStimulus();
        clearInsert();
        checkOutput("t7_pre", rs_fu_robid, 8'd70);
        #2 rst = 1'b1;
        #1;
        checkOutput("t7_async_valid", rs_fu_valid, 0);
        checkOutput("t7_async_stall", rs_stall, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus();
        checkOutput("t7_no_survivor", rs_fu_valid, 0);
        applyStimulus();
        checkOutput("t7_no_survivor2", rs_fu_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rs_sched.md
Name: rs_sched

Overview:
- Reservation station directly downstream of the register alias table.
- Captures renamed instructions together with the RAT's per-operand valid/tag-or-value outputs.
- Snoops the writeback bus (CDB) to wake waiting operands.
- Issues one ready instruction per cycle to a single functional unit through a valid/stall output register.

Parameters:
- NENT, 8, number of entries (power of two, 2..16).
- OPW, 8, width of the opaque op/control field carried to the FU.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rename_rs_valid  in  1  insert request; fields aligned with the RAT output cycle
- rename_rs_op  in  OPW  op/control field
- rename_rs_robid  in  8  ROB id of the instruction
- rename_rs_rd  in  6  destination; bit5 set = no register write
- rat_rs1_valid  in  1  1 = rat_rs1_tagval is a value, 0 = it is a tag
- rat_rs1_tagval  in  32  value, or tag in bits [6:0]
- rat_rs2_valid  in  1  as rs1
- rat_rs2_tagval  in  32  as rs1
- rs_stall  out  1  station full; insert ignored
- wb_valid  in  1  CDB valid
- wb_error  in  1  CDB result is an exception
- wb_robid  in  8  CDB producer ROB id
- wb_result  in  32  CDB value
- rob_flush  in  1  discard all state
- rs_fu_valid  out  1  issue valid
- fu_rs_stall  in  1  FU cannot accept
- rs_fu_op  out  OPW  issued op
- rs_fu_robid  out  8  issued ROB id
- rs_fu_rd  out  6  issued destination
- rs_fu_op1  out  32  operand 1 value
- rs_fu_op2  out  32  operand 2 value

Behaviour:
- Entry state: busy, op, robid, rd, and per operand a rdy bit plus a 32-bit tag-or-value.
- Reset (async): all busy=0, rs_fu_valid=0, rs_stall=0. Data outputs are don't-care but are driven 0.
- rs_stall is combinational: high when all NENT entries are busy at the start of the cycle.
  - A free occurring in the same cycle does not lower it.
- Insert: when rename_rs_valid & ~rs_stall, write the lowest-index free entry at the edge.
  - rdy = rat_rsN_valid.
- Wakeup condition: wb_valid & ~wb_error.
  - Every busy entry with rdy=0 and tag[6:0]==wb_robid[6:0] captures wb_result and sets rdy=1.
  - The same compare applies to operands being inserted this cycle.
  - Both operands of one entry may wake on the same broadcast.
  - wb_error=1 never wakes anything; the ROB flushes before that matters.
- Ready: busy & rdy1 & rdy2.
- Select: lowest-index ready entry (see the optional feature for oldest-first).
  - Selection uses state from before the current edge.
  - An entry inserted or woken at edge E is first selectable in the cycle after E.
- Issue register behaviour:
  - Loads when (~rs_fu_valid | ~fu_rs_stall) and a ready entry exists.
  - Load copies op/robid/rd/values and clears that entry's busy at the same edge.
  - If it can load but nothing is ready, rs_fu_valid drops to 0.
  - While rs_fu_valid & fu_rs_stall, all rs_fu_* outputs hold stable.
- Minimum latency: insert with both operands ready at edge E gives rs_fu_valid=1 after edge E+1.
- Simultaneous insert and issue-free on the same edge is legal. The freed slot is reusable at the next edge.
- rob_flush (sampled at the edge) wins over insert, wakeup, and issue:
  - All busy=0 and rs_fu_valid=0.
  - An output held under fu_rs_stall is dropped.
- rst asserted mid-operation clears immediately; no partial entries survive.

Optional Feature:
- Macro RS_AGE_SELECT_EN.
- When defined:
  - An NENT×NENT age matrix is maintained; the row of an inserted entry is set older-than-none.
  - Columns of other busy entries mark them older.
  - Select picks the ready entry with no older ready entry.
- When undefined: lowest-index priority; no age storage.

Test Plan:
- Reset then insert robid=5, both valid, op1=0x11, op2=0x22 -> rs_fu_valid=1 two edges later with robid=5, op1=0x11, op2=0x22; rs_stall=0.
- Insert robid=9 with rs1 tag=0x03 (valid=0); next cycle wb_valid, wb_robid=3, wb_result=0xDEADBEEF -> issues one cycle after the wakeup with op1=0xDEADBEEF. Repeat with wb_error=1 -> never issues.
- Insert 8 entries all waiting on tag 7 -> rs_stall=1, a 9th insert is ignored. Broadcast robid=7 -> entries issue one per cycle; rs_stall clears after the first issue edge.
- Two ready entries with fu_rs_stall=1 for 3 cycles -> outputs hold the first instruction unchanged. Release -> second issues the next cycle with no duplicate or loss.
- Fill 4 entries, rob_flush for one cycle while rs_fu_valid=1 and stalled -> rs_fu_valid=0 next cycle. A subsequent wb matching an old tag issues nothing.
- With RS_AGE_SELECT_EN: insert A (waiting) into slot 0, then B (ready) into slot 1, then wake A -> B issues first. A issues next even if a newer ready C sits in slot 2.
